sync_pulse_master: RTL and testbench

SYNC_PULSE_MASTER -- requirements
Module: sync_pulse_master

---
 rtl/sync_pulse_master.sv | 174 +++++++++++++++++
 tb/tb_sync_pulse_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_master.sv
// Serial-register driven sync pulse generator: a programmable delay, a pulse of
// programmable width on sync_out, and a lag-compensated copy on sync_local.

`ifndef FR_RX_MASTER_SLAVE
`define FR_RX_MASTER_SLAVE 7'd64
`endif

module sync_pulse_master #(
  parameter logic [6:0] ADDR = 7'(`FR_RX_MASTER_SLAVE + 1)
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  output logic        sync_out,
  output logic        sync_local,
  output logic        busy,
  output logic [15:0] done_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] dcnt_q, dcnt_n;
  logic [7:0]  wcnt_q, wcnt_n;
  logic [3:0]  lcnt_q, lcnt_n;
  logic [15:0] d_q, d_n;
  logic [7:0]  w_q, w_n;
  logic [3:0]  l_q, l_n;
  logic [14:0] line_q, line_n;
  logic        sync_out_q, sync_out_n;
  logic        sync_local_q, sync_local_n;
  logic        busy_q, busy_n;
  logic [15:0] done_q, done_n;

  logic        accept, abort_req, go_req, start, finish;
  logic [15:0] wr_d;
  logic [7:0]  wr_w;
  logic [3:0]  wr_l;
  logic [3:0]  lag_eff;
  logic        unused_bits;

  // Serial bus handshake: there is no back-pressure; a write is a single-cycle
  // serial_strobe qualified by serial_addr==ADDR, consumed on that same edge.
  assign accept    = serial_strobe && (serial_addr == ADDR);
  assign abort_req = accept && serial_data[30];
  assign go_req    = accept && serial_data[31] && !serial_data[30];
  assign start     = go_req && (state_q == ST_IDLE);

  assign wr_d        = serial_data[15:0];
  assign wr_w        = (serial_data[23:16] == 8'd0) ? 8'd1 : serial_data[23:16];
  assign wr_l        = serial_data[27:24];
  assign unused_bits = ^serial_data[29:28];

  always_comb begin
    state_n = state_q;
    dcnt_n  = dcnt_q;
    wcnt_n  = wcnt_q;
    lcnt_n  = lcnt_q;
    d_n     = d_q;
    w_n     = w_q;
    l_n     = l_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_n = wr_d;
          w_n = wr_w;
          l_n = wr_l;
          if (wr_d == 16'd0) begin
            state_n = ST_PULSE;
            wcnt_n  = 8'd0;
          end else begin
            state_n = ST_DELAY;
            dcnt_n  = 16'd0;
          end
        end
      end
      ST_DELAY: begin
        if (dcnt_q == d_q - 16'd1) begin
          state_n = ST_PULSE;
          wcnt_n  = 8'd0;
        end else begin
          dcnt_n = dcnt_q + 16'd1;
        end
      end
      ST_PULSE: begin
        if (wcnt_q == w_q - 8'd1) begin
          if (l_q == 4'd0) begin
            state_n = ST_IDLE;
            finish  = 1'b1;
          end else begin
            state_n = ST_TAIL;
            lcnt_n  = 4'd0;
          end
        end else begin
          wcnt_n = wcnt_q + 8'd1;
        end
      end
      ST_TAIL: begin
        if (lcnt_q == l_q - 4'd1) begin
          state_n = ST_IDLE;
          finish  = 1'b1;
        end else begin
          lcnt_n = lcnt_q + 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_req && (state_q != ST_IDLE)) begin
      state_n = ST_IDLE;
      finish  = 1'b0;
    end
  end

  // The output flop is the last stage of the lag line, so 15 line stages
  // cover the full L=15 range. The line only holds history of the current run.
  always_comb begin
    lag_eff      = start ? wr_l : l_q;
    line_n       = ((state_q == ST_IDLE) || abort_req) ? 15'd0 : {line_q[13:0], sync_out_q};
    sync_out_n   = (state_n == ST_PULSE);
    busy_n       = (state_n != ST_IDLE);
    sync_local_n = 1'b0;
    if (state_n != ST_IDLE) begin
      if (lag_eff == 4'd0) sync_local_n = sync_out_n;
      else                 sync_local_n = line_n[lag_eff - 4'd1];
    end
    done_n = finish ? done_q + 16'd1 : done_q;
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dcnt_q       <= 16'd0;
      wcnt_q       <= 8'd0;
      lcnt_q       <= 4'd0;
      d_q          <= 16'd0;
      w_q          <= 8'd0;
      l_q          <= 4'd0;
      line_q       <= 15'd0;
      sync_out_q   <= 1'b0;
      sync_local_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 16'd0;
    end else begin
      state_q      <= state_n;
      dcnt_q       <= dcnt_n;
      wcnt_q       <= wcnt_n;
      lcnt_q       <= lcnt_n;
      d_q          <= d_n;
      w_q          <= w_n;
      l_q          <= l_n;
      line_q       <= line_n;
      sync_out_q   <= sync_out_n;
      sync_local_q <= sync_local_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
    end
  end

  assign sync_out   = sync_out_q;
  assign sync_local = sync_local_q;
  assign busy       = busy_q;
  assign done_count = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sync_pulse_master.sv
// Bench for sync_pulse_master: a timing-formula model feeds a per-cycle expected
// queue, plus a table of sequences and hand-written corner-case sequences.

module tb_sync_pulse_master;

  localparam logic [6:0] ADDR       = 7'd65;
  localparam logic [6:0] ADDR_OTHER = 7'd66;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        sync_out, sync_local, busy;
  logic [15:0] done_count;
  logic [1:0]  dbg_state;

  sync_pulse_master #(.ADDR(ADDR)) dut (
    .master_clk   (clk),
    .reset        (reset),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .sync_out     (sync_out),
    .sync_local   (sync_local),
    .busy         (busy),
    .done_count   (done_count),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int w;
    int l;
    int exp_so_cnt;
    int exp_sl_first;
    int exp_last_busy;
  } vec_t;

  vec_t        tbl[8];
  int          vectors = 0;
  int          miscompares = 0;
  logic [19:0] exp_q[$];

  // model state: sequence accepted at cycle m_n with fields m_d/m_w/m_l
  int          cyc = 0;
  bit          m_act = 0;
  bit          m_busy = 0;
  int          m_n, m_d, m_w, m_l;
  logic [15:0] m_done = 16'd0;
  bit          preload_req = 0;
  logic [15:0] preload_val = 16'd0;

  function automatic logic [31:0] word(input int d, input int w, input int l,
                                       input bit abort, input bit go);
    word = {go, abort, 2'b00, 4'(l), 8'(w), 16'(d)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_loop();
    bit   acc;
    int   t, endc;
    logic e_so, e_sl, e_busy;
    forever begin
      @(posedge clk);
      t = cyc + 1;
      if (preload_req) m_done = preload_val;
      acc = serial_strobe && (serial_addr == ADDR);
      if (reset) begin
        m_act  = 0;
        m_done = 16'd0;
      end else if (acc && serial_data[30]) begin
        m_act = 0;
      end else if (acc && serial_data[31] && !m_busy) begin
        m_act = 1;
        m_n   = cyc;
        m_d   = int'(serial_data[15:0]);
        m_w   = (serial_data[23:16] == 8'd0) ? 1 : int'(serial_data[23:16]);
        m_l   = int'(serial_data[27:24]);
      end
      e_so = 1'b0; e_sl = 1'b0; e_busy = 1'b0;
      if (m_act) begin
        endc = m_n + m_d + m_w + m_l;
        if (t > endc) begin
          m_act  = 0;
          m_done = m_done + 16'd1;
        end else begin
          e_busy = 1'b1;
          e_so   = (t >= m_n + 1 + m_d) && (t <= m_n + m_d + m_w);
          e_sl   = (t >= m_n + 1 + m_d + m_l) && (t <= m_n + m_d + m_w + m_l);
        end
      end
      m_busy = e_busy;
      exp_q.push_back({!e_busy, e_so, e_sl, e_busy, m_done});
      cyc++;
    end
  endtask

  task automatic monitor_loop();
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d {idle,so,sl,busy,done}", cyc),
              32'({dbg_state == 2'd0, sync_out, sync_local, busy, done_count}), 32'(e));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_now(input logic [6:0] a, input logic [31:0] dw);
    serial_addr   = a;
    serial_data   = dw;
    serial_strobe = 1'b1;
    @(posedge clk);
    #1;
    serial_strobe = 1'b0;
    serial_addr   = 7'd0;
    serial_data   = 32'd0;
  endtask

  // Watches from the current cycle (offset off0) until busy drops.
  task automatic observe(input int off0, input int limit, output int so_n, output int so_first,
                         output int sl_first, output int last_busy);
    bit ended;
    ended = 0; so_n = 0; so_first = -1; sl_first = -1; last_busy = -1;
    for (int k = off0; (k < off0 + limit) && !ended; k++) begin
      @(negedge clk);
      if (sync_out) begin
        so_n++;
        if (so_first < 0) so_first = k;
      end
      if (sync_local && (sl_first < 0)) sl_first = k;
      if (busy) last_busy = k;
      else ended = 1;
    end
    if (!ended) begin
      vectors++;
      miscompares++;
      $display("FAIL observe_timeout: busy still 1 after %0d cycles, expected 0", limit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int d, input int w, input int l, output int so_n,
                         output int sl_first, output int last_busy, output logic [15:0] delta);
    logic [15:0] done0;
    int          so_first;
    done0 = done_count;
    write_now(ADDR, word(d, w, l, 0, 1));
    observe(1, 400, so_n, so_first, sl_first, last_busy);
    delta = done_count - done0;
  endtask

  initial begin
    int          so_n, so_first, sl_first, last_busy, sl_hits;
    logic [15:0] delta, done_before;

    reset = 1'b1; serial_strobe = 1'b0; serial_addr = 7'd0; serial_data = 32'd0;
    fork
      model_loop();
      monitor_loop();
    join_none

    tbl[0] = '{3, 2, 0, 2, 4, 5};
    tbl[1] = '{0, 0, 4, 1, 5, 5};
    tbl[2] = '{0, 1, 0, 1, 1, 1};
    tbl[3] = '{5, 0, 15, 1, 21, 21};
    tbl[4] = '{1, 255, 0, 255, 2, 256};
    tbl[5] = '{20, 7, 2, 7, 23, 29};
    tbl[6] = '{0, 3, 1, 3, 2, 4};
    tbl[7] = '{2, 1, 9, 1, 12, 12};

    idle(3);
    reset = 1'b0;
    idle(2);
    check("reset_done_count", 32'(done_count), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_seq(tbl[i].d, tbl[i].w, tbl[i].l, so_n, sl_first, last_busy, delta);
      check($sformatf("tbl%0d_sync_out_cycles", i), 32'(so_n), 32'(tbl[i].exp_so_cnt));
      check($sformatf("tbl%0d_sync_local_first", i), 32'(sl_first), 32'(tbl[i].exp_sl_first));
      check($sformatf("tbl%0d_busy_last", i), 32'(last_busy), 32'(tbl[i].exp_last_busy));
      check($sformatf("tbl%0d_done_delta", i), 32'(delta), 32'd1);
      idle(2);
    end

    // go while busy is ignored
    write_now(ADDR, word(100, 8, 0, 0, 1));
    idle(9);
    write_now(ADDR, word(0, 1, 0, 0, 1));
    observe(11, 200, so_n, so_first, sl_first, last_busy);
    check("busy_go_so_first", 32'(so_first), 32'd101);
    check("busy_go_so_cycles", 32'(so_n), 32'd8);
    check("busy_go_busy_last", 32'(last_busy), 32'd108);
    idle(2);

    // abort mid-sequence, then writes that must not start anything
    done_before = done_count;
    write_now(ADDR, word(10, 4, 3, 0, 1));
    idle(11);
    write_now(ADDR, word(0, 0, 0, 1, 0));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sync_out", 32'(sync_out), 32'd0);
    check("abort_sync_local", 32'(sync_local), 32'd0);
    check("abort_done", 32'(done_count), 32'(done_before));
    write_now(ADDR_OTHER, word(0, 1, 0, 0, 1));
    check("other_addr_busy", 32'(busy), 32'd0);
    write_now(ADDR, word(0, 1, 0, 1, 1));
    check("abort_and_go_busy", 32'(busy), 32'd0);
    write_now(ADDR, word(0, 0, 0, 1, 0));
    check("idle_abort_done", 32'(done_count), 32'(done_before));
    idle(3);

    // go in the cycle busy falls is ignored; the following cycle starts
    write_now(ADDR, word(0, 2, 0, 0, 1));
    idle(1);
    write_now(ADDR, word(0, 1, 0, 0, 1));
    check("fall_cycle_go_busy", 32'(busy), 32'd0);
    write_now(ADDR, word(0, 1, 0, 0, 1));
    check("next_cycle_go_busy", 32'(busy), 32'd1);
    idle(3);

    // done_count wrap: preload near the top
    @(negedge clk);
    #1;
    force dut.done_q = 16'hFFFE;
    preload_val = 16'hFFFE;
    preload_req = 1;
    @(posedge clk);
    #1;
    release dut.done_q;
    preload_req = 0;
    idle(1);
    run_seq(0, 1, 0, so_n, sl_first, last_busy, delta);
    check("wrap_pre_count", 32'(done_count), 32'hFFFF);
    run_seq(3, 1, 0, so_n, sl_first, last_busy, delta);
    check("wrap_count", 32'(done_count), 32'h0000);
    idle(2);

    // reset during PULSE with L=5
    write_now(ADDR, word(2, 10, 5, 0, 1));
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_sync_out", 32'(sync_out), 32'd0);
    check("rst_sync_local", 32'(sync_local), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    sl_hits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sync_local) sl_hits++;
    end
    check("rst_no_residual_sync_local", 32'(sl_hits), 32'd0);
    idle(1);

    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end
      write_now(($urandom_range(0, 7) == 0) ? ADDR_OTHER : ADDR,
                word($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 15),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0));
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
